// File: rtl/demux_pkg.sv
// Shared types and helpers for the bit-serial 1:8 deserializer.
// Helpers use 32-bit values; callers cast down to their own widths.
package demux_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_SEL_W = 3;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic logic [31:0] onehot(input logic [31:0] pos);
    return 32'd1 << pos;
  endfunction

  // Word position written for a given select value.
  function automatic logic [31:0] map_pos(input logic [31:0] sel, input logic msb_first,
                                          input logic [31:0] width);
    return msb_first ? (width - 32'd1 - sel) : sel;
  endfunction

endpackage

// File: rtl/demux8_deser_out_stage.sv
// Single-entry output register with valid/ready handshake.
// A load and a transfer in the same cycle replace the word without a bubble.
module out_stage
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             load_ok
);

  out_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (load)
      state_d = OUT_FULL;
    else if (state_q == OUT_FULL && out_ready)
      state_d = OUT_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst)       out_data <= '0;
    else if (load) out_data <= load_data;
  end

  assign out_valid = (state_q == OUT_FULL);
  // A new word may be loaded when the slot is empty or is being drained now.
  assign load_ok   = !out_valid || out_ready;

endmodule

// File: rtl/demux8_deser.sv
// Bit-serial 1:WIDTH deserializer: select counter, assembly register and strobe,
// feeding a double-buffered output stage; only the completing bit can stall.
module demux8_deser
  import demux_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int SEL_W     = DEFAULT_SEL_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] strobe,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] asm_wr;
  logic [WIDTH-1:0] strobe_q;
  logic [SEL_W-1:0] pos;
  logic             last;
  logic             accept;
  logic             complete;
  logic             load_ok;

  assign pos      = SEL_W'(map_pos(32'(sel_q), MSB_FIRST, 32'(WIDTH)));
  assign last     = (sel_q == SEL_W'(WIDTH - 1));
  assign in_ready = !last || load_ok;
  assign accept   = in_valid && in_ready;
  assign complete = accept && last;

  always_comb begin
    asm_wr      = asm_q;
    asm_wr[pos] = in_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      asm_q    <= '0;
      strobe_q <= '0;
    end else begin
      strobe_q <= accept ? WIDTH'(onehot(32'(pos))) : '0;
      if (accept) begin
        if (last) begin
          sel_q <= '0;
          asm_q <= '0;
        end else begin
          sel_q <= sel_q + SEL_W'(1);
          asm_q <= asm_wr;
        end
      end
    end
  end

  out_stage #(.WIDTH(WIDTH)) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .load      (complete),
    .load_data (asm_wr),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .load_ok   (load_ok)
  );

  assign sel    = sel_q;
  assign strobe = strobe_q;

endmodule

// File: tb/tb_demux8_deser.sv
// Bench for demux8_deser: LSB-first and MSB-first instances share stimulus and are
// checked against a queue-based model, table vectors and hand-written corner sequences.
module tb_demux8_deser;

  logic       clk = 1'b0;
  logic       rst, in_bit, in_valid, out_ready;
  logic       in_ready_l, in_ready_m, valid_l, valid_m;
  logic [2:0] sel_l, sel_m;
  logic [7:0] strobe_l, strobe_m, data_l, data_m;

  always #5 clk = ~clk;

  demux8_deser #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready_l),
    .sel(sel_l), .strobe(strobe_l), .out_data(data_l), .out_valid(valid_l),
    .out_ready(out_ready));

  demux8_deser #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready_m),
    .sel(sel_m), .strobe(strobe_m), .out_data(data_m), .out_valid(valid_m),
    .out_ready(out_ready));

  int checks = 0;
  int failures = 0;

  // Model: bits collected so far for the current word, plus one pending output word.
  bit         q[$];
  logic       m_full;
  logic [7:0] m_word_l, m_word_m;

  typedef struct {
    logic [7:0] stream;   // stream[k] is the k-th serial bit
    logic [7:0] exp_lsb;
    logic [7:0] exp_msb;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic b, input logic r);
    logic       exp_rdy, acc;
    logic [7:0] sl, sm;
    in_valid = v; in_bit = b; out_ready = r;
    #1;
    exp_rdy = !(q.size() == 7 && m_full && !r);
    chk("in_ready_lsb", 32'(in_ready_l), 32'(exp_rdy));
    chk("in_ready_msb", 32'(in_ready_m), 32'(exp_rdy));
    acc = v && exp_rdy;
    sl  = acc ? 8'(1 << q.size()) : 8'h00;
    sm  = acc ? 8'(8'h80 >> q.size()) : 8'h00;
    if (m_full && r) m_full = 1'b0;
    if (acc) begin
      q.push_back(b);
      if (q.size() == 8) begin
        m_word_l = '0;
        m_word_m = '0;
        foreach (q[k]) begin
          m_word_l[k]     = q[k];
          m_word_m[7 - k] = q[k];
        end
        m_full = 1'b1;
        q.delete();
      end
    end
    @(posedge clk);
    #1;
    chk("sel_lsb", 32'(sel_l), 32'(q.size()));
    chk("sel_msb", 32'(sel_m), 32'(q.size()));
    chk("strobe_lsb", 32'(strobe_l), 32'(sl));
    chk("strobe_msb", 32'(strobe_m), 32'(sm));
    chk("out_valid_lsb", 32'(valid_l), 32'(m_full));
    chk("out_valid_msb", 32'(valid_m), 32'(m_full));
    if (m_full) begin
      chk("out_data_lsb", 32'(data_l), 32'(m_word_l));
      chk("out_data_msb", 32'(data_m), 32'(m_word_m));
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'($urandom);
    in_bit = 1'($urandom);
    out_ready = 1'($urandom);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_full = 1'b0;
    chk("rst_sel", 32'(sel_l), 32'd0);
    chk("rst_valid", 32'(valid_l), 32'd0);
    chk("rst_data", 32'(data_l), 32'd0);
    chk("rst_strobe", 32'(strobe_l), 32'd0);
    chk("rst_data_msb", 32'(data_m), 32'd0);
    chk("rst_valid_msb", 32'(valid_m), 32'd0);
  endtask

  task automatic send_word(input logic [7:0] st, input logic r);
    for (int k = 0; k < 8; k++) cyc(1'b1, st[k], r);
  endtask

  initial begin
    logic [7:0] st;
    rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    m_full = 1'b0; m_word_l = '0; m_word_m = '0;

    tbl[0] = '{8'h63, 8'h63, 8'hC6};
    tbl[1] = '{8'h01, 8'h01, 8'h80};
    tbl[2] = '{8'hF0, 8'hF0, 8'h0F};
    tbl[3] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[4] = '{8'h3C, 8'h3C, 8'h3C};
    tbl[5] = '{8'h81, 8'h81, 8'h81};

    do_reset(2);

    // Reset mid-word discards the partial word.
    cyc(1'b1, 1'b1, 1'b1); cyc(1'b1, 1'b0, 1'b1); cyc(1'b1, 1'b1, 1'b1);
    do_reset(2);
    send_word(tbl[0].stream, 1'b1);
    chk("post_rst_word", 32'(data_l), 32'h63);
    cyc(1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      send_word(tbl[i].stream, 1'b1);
      chk("tbl_valid", 32'(valid_l), 32'd1);
      chk("tbl_lsb", 32'(data_l), 32'(tbl[i].exp_lsb));
      chk("tbl_msb", 32'(data_m), 32'(tbl[i].exp_msb));
      cyc(1'b0, 1'b0, 1'b1);
    end

    // Backpressure: A5 held while 3C assembles and stalls on its last bit.
    send_word(8'hA5, 1'b0);
    st = 8'h3C;
    for (int k = 0; k < 7; k++) cyc(1'b1, st[k], 1'b0);
    repeat (3) cyc(1'b1, st[7], 1'b0);
    chk("bp_stall_rdy", 32'(in_ready_l), 32'd0);
    chk("bp_held", 32'(data_l), 32'hA5);
    cyc(1'b1, st[7], 1'b1);
    chk("bp_second", 32'(data_l), 32'h3C);
    chk("bp_second_valid", 32'(valid_l), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("bp_drained", 32'(valid_l), 32'd0);

    // Completion coinciding with transfer of the previous word.
    send_word(8'h11, 1'b0);
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("simul_valid", 32'(valid_l), 32'd1);
    chk("simul_data", 32'(data_l), 32'hFF);
    cyc(1'b0, 1'b0, 1'b1);

    // Gapped input: valid pattern 1,0,0 per bit.
    st = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, st[k], 1'b1);
      cyc(1'b0, 1'($urandom), 1'b1);
      if (k != 7) cyc(1'b0, 1'($urandom), 1'b1);
    end
    chk("gap_data_lsb", 32'(data_l), 32'h5A);
    chk("gap_data_msb", 32'(data_m), 32'h5A);
    cyc(1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 400; n++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux8_deser.md
Name: demux8_deser

Overview:
- Bit-serial 1:8 demultiplexer / deserializer: the receiving end of the 8:1 mux path.
- When an upstream 8:1 mux is stepped through select 0..7, it emits one bit per cycle. This block writes each accepted bit into the word position addressed by an internal select counter.
- Each completed word is presented on a registered output with a valid/ready handshake.
- Double-buffered: assembly of the next word continues while the previous word waits for the consumer.

Parameters:
- WIDTH, 8, number of bits per word (output width).
- SEL_W, 3, select counter width; must equal clog2(WIDTH).
- MSB_FIRST, 0, 0 = first serial bit lands in bit 0 (matches mux select 0 -> i[0]); 1 = first bit lands in bit WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_bit  input  1  serial data bit (the mux output o).
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  block accepts in_bit this cycle.
- sel  output  SEL_W  current select value; drives the upstream mux s so both ends stay aligned.
- strobe  output  WIDTH  registered one-hot of the position written in the previous accept cycle; 0 otherwise.
- out_data  output  WIDTH  completed word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer takes out_data when out_valid && out_ready.

Behaviour:
- Accept condition: in_valid && in_ready. Transfer condition: out_valid && out_ready.
- Reset (rst=1 at a clk edge): sel=0, assembly register=0, out_data=0, out_valid=0, strobe=0.
  - Reset overrides every other input that cycle.
  - A partially assembled word is discarded.
- Position mapping: pos = sel when MSB_FIRST=0, pos = WIDTH-1-sel when MSB_FIRST=1.
- On accept:
  - asm[pos] <= in_bit.
  - strobe <= one-hot(pos).
  - If sel < WIDTH-1: sel <= sel+1.
- Word completion (accept while sel == WIDTH-1):
  - out_data <= asm with bit pos replaced by in_bit.
  - out_valid <= 1; sel <= 0; asm <= 0.
- Latency: out_valid rises on the clock edge that accepts the last bit, so it is visible the cycle after that accept.
- in_ready = !(sel == WIDTH-1 && out_valid && !out_ready).
  - Only the completing bit can be stalled. Bits 0..WIDTH-2 of the next word are always accepted.
  - in_ready is combinational on out_valid/out_ready. There is no combinational path from in_valid.
- Simultaneous completion and transfer (last-bit accept while out_valid && out_ready): out_data is replaced with the new word and out_valid stays 1. No bubble, no loss.
- Transfer without completion: out_valid <= 0. out_data holds its value, which is don't-care once invalid.
- No accept: sel and asm hold; strobe <= 0.
- sel never exceeds WIDTH-1; wrap from WIDTH-1 to 0 occurs only at completion.
- State summary: a counter-based FSM.
  - COLLECT: sel 0..WIDTH-1.
  - Output stage EMPTY/FULL: out_valid.
  - Combined states: {COLLECT, EMPTY}, {COLLECT, FULL}, and the stall point {sel=WIDTH-1, FULL, !out_ready}.
- in_valid=0 mid-word: the block waits indefinitely; there is no timeout.

Decomposition:
- Shared package demux_pkg holds:
  - localparam DEFAULT_WIDTH=8 and DEFAULT_SEL_W=3.
  - A function onehot(pos) returning a WIDTH vector.
  - A function map_pos(sel, msb_first).
- One natural sub-module: out_stage, the single-entry output register with valid/ready, load and transfer logic, and an in_ready contribution.
- Counter, assembly register and strobe logic stay in the top.

Test Plan:
- Reset: assert rst for 2 cycles mid-word after 3 bits -> sel=0, out_valid=0, out_data=0, strobe=0. Next 8 bits form a clean word.
- Basic LSB-first, MSB_FIRST=0, out_ready=1: bits 1,1,0,0,0,1,1,0 on consecutive cycles -> out_data=8'h63 and out_valid=1 one cycle after the 8th accept. Strobe walks 8'h01..8'h80.
- MSB_FIRST=1: same bit stream -> out_data=8'hC6. First strobe=8'h80.
- Backpressure: out_ready=0, send 2 full words 8'hA5 then 8'h3C -> first word held (out_data=8'hA5). in_ready=0 only at sel=7. Raising out_ready yields 8'hA5, then 8'h3C next cycle. No bit lost.
- Simultaneous completion and transfer: out_valid=1, out_ready=1 on the cycle the 8th bit of 8'hFF is accepted -> out_valid stays 1 and out_data=8'hFF on the next cycle.
- Gapped input: in_valid toggles 1,0,0,1... across 8 bits of 8'h5A -> sel advances only on accept, strobe=0 on idle cycles, out_data=8'h5A.
